// File: rtl/uc_fsm.sv
// Control unit for the small accumulator CPU: combinational instruction decode
// plus a three-state sequencer (RUN/SKIP/HALTED) and a saturating retired-instruction counter.
module uc_fsm #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Opcode,
   input  logic             z,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we3,
   output logic             wez,
   output logic [2:0]       Op,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_SKIP   = 2'd1,
      S_HALTED = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             illegal_q;
   logic [CNT_W-1:0] instret_q;
   logic             exec;
   logic             illegal_set;

   // NOTE: every output gets its default first, so no path can leave a latch behind.
   always_comb begin
      s_inc       = 1'b1;
      s_inm       = 1'b0;
      we3         = 1'b0;
      wez         = 1'b0;
      Op          = 3'b000;
      state_d     = state_q;
      exec        = 1'b0;
      illegal_set = 1'b0;

      if (!reset) begin
         unique case (state_q)
            S_RUN: begin
               exec = 1'b1;
               if (!Opcode[5]) begin
                  Op  = Opcode[4:2];
                  we3 = 1'b1;
                  wez = 1'b1;
               end else begin
                  casez (Opcode[4:0])
                     5'b000??: begin
                        s_inm = 1'b1;
                        we3   = 1'b1;
                     end
                     5'b00100: s_inc = 1'b0;
                     5'b00101: s_inc = ~z;
                     5'b00110: s_inc = z;
                     5'b00111: if (z) state_d = S_SKIP;
                     5'b01000: begin
                        s_inc   = 1'b0;
                        state_d = S_HALTED;
                     end
                     5'b01001: ;
                     default:  illegal_set = 1'b1;
                  endcase
               end
            end
            S_SKIP:   state_d = S_RUN;
            S_HALTED: s_inc   = 1'b0;
            default:  state_d = S_RUN;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_RUN;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (illegal_set)
            illegal_q <= 1'b1;
         if (exec && (instret_q != {CNT_W{1'b1}}))
            instret_q <= instret_q + 1'b1;
      end
   end

   assign halted  = (state_q == S_HALTED);
   assign illegal = illegal_q;
   assign instret = instret_q;

endmodule

// File: doc/uc_fsm.md
UC_FSM -- requirements
Module: uc_fsm

Interface
REQ-001 Parameter: CNT_W, default 16, width of the retired-instruction counter.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: Opcode  input  6  instruction bits [15:10] from the datapath.
REQ-005 Port: z  input  1  registered zero flag from the datapath.
REQ-006 Port: s_inc  output  1  PC source select; 1 = PC+1, 0 = jump target instr[9:0].
REQ-007 Port: s_inm  output  1  register write data select; 1 = immediate instr[11:4], 0 = ALU result.
REQ-008 Port: we3  output  1  register file write enable.
REQ-009 Port: wez  output  1  zero flag write enable.
REQ-010 Port: Op  output  3  ALU operation code.
REQ-011 Port: halted  output  1  high while the FSM is in HALTED.
REQ-012 Port: illegal  output  1  sticky flag; an undefined opcode has executed since reset.
REQ-013 Port: instret  output  CNT_W  count of executed instructions.

Function
REQ-014 Decode, in RUN state: Opcode[5]=0 is an ALU op: Op=Opcode[4:2], we3=1, wez=1, s_inm=0, s_inc=1; Opcode[1:0] are ignored.
REQ-015 Opcode[5:2]=1000 is LI: s_inm=1, we3=1, wez=0, s_inc=1.
REQ-016 Opcode=100100 is J: s_inc=0, no writes.
REQ-017 Opcode=100101 is JZ: s_inc=~z; Opcode=100110 is JNZ: s_inc=z; no writes.
REQ-018 Opcode=100111 is SKZ: s_inc=1, no writes; if z=1, next state is SKIP, else RUN.
REQ-019 Opcode=101000 is HALT: s_inc=0, no writes; next state is HALTED.
REQ-020 Opcode=101001 is NOP: s_inc=1, no writes.
REQ-021 Any other opcode executes as NOP and sets illegal on the next edge.
REQ-022 When not driven by a decode rule, outputs take these defaults: s_inm=0, Op=000, we3=0, wez=0, s_inc=1.
REQ-023 FSM has three states: RUN, SKIP and HALTED.
- RUN -> SKIP on SKZ with z=1.
- RUN -> HALTED on HALT.
- SKIP -> RUN unconditionally after one cycle.
- HALTED -> RUN only on reset.
REQ-024 In SKIP, the current instruction is annulled regardless of opcode: s_inc=1, we3=0, wez=0, instret and illegal unchanged. This includes J, HALT, SKZ and illegal opcodes.
REQ-025 In HALTED: s_inc=0, we3=0, wez=0, halted=1, instret frozen. The HALT word carries its own address, so the PC holds.
REQ-026 All control outputs are combinational from state, Opcode and z; zero latency within the cycle. halted, illegal and instret are registered.
REQ-027 instret increments by 1 on every rising edge on which an instruction executes in RUN, legal or illegal, HALT included. It saturates at 2^CNT_W-1 and never wraps.
REQ-028 JZ and JNZ use the z value present in the same cycle. A preceding ALU op's wez update is visible one cycle later, with no forwarding.

Reset
REQ-029 While reset=1, outputs are forced combinationally to s_inc=1, we3=0, wez=0, s_inm=0, Op=000, overriding all state.
REQ-030 On a rising edge with reset=1: state=RUN, halted=0, illegal=0, instret=0.
REQ-031 Reset asserted in SKIP or HALTED behaves identically to reset from RUN; no skip is pending after reset.
REQ-032 The first cycle after reset deasserts decodes normally in RUN.

Verification
REQ-033 Reset, then ALU op Opcode=000100 (Op=001): expect s_inc=1, we3=1, wez=1, s_inm=0, Op=001; next cycle instret=1.
REQ-034 LI then JZ: with z=1, JZ gives s_inc=0; with z=0, s_inc=1; instret=2 after both.
REQ-035 SKZ with z=1 followed by J: J cycle gives s_inc=1, we3=0; instret counts only SKZ; state returns to RUN. SKZ with z=0 followed by J gives s_inc=0.
REQ-036 HALT: halted=1 from the next cycle, s_inc=0, we3=0 for 10 cycles, instret constant. Reset then gives halted=0, instret=0.
REQ-037 Opcode=111111: behaves as NOP, illegal=1 next cycle and remains 1 until reset. The same opcode in SKIP leaves illegal=0.
REQ-038 With CNT_W=4: 20 NOPs leave instret=15. Reset asserted mid-SKIP leaves the next instruction executing normally.
